traffic_phase_scheduler: RTL
============================

Name: traffic_phase_scheduler

Overview:
- Demand-driven phase scheduler for the four-road intersection.
- Replaces the fixed R1→R4 rotation with a round-robin arbiter over vehicle-waiting sensors. Enforces min/max green, yellow and all-red clearance, and serves emergency requests through a safe yellow/clearance sequence.
- Drives per-road light codes plus a grant index for downstream display/ASCII-encoding logic.

Parameters:
- T_MIN_GREEN, 32'd10000000, minimum green duration in cycles (≥1)
- T_MAX_GREEN, 32'd40000000, maximum green duration when another road is waiting (≥T_MIN_GREEN)
- T_YELLOW, 32'd3000000, yellow duration in cycles (≥1)
- T_ALL_RED, 32'd1000000, all-red clearance duration in cycles (≥1); used only with ALL_RED_EN

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous reset, active-high
- veh_req  input  4  level vehicle-waiting sensor; bit k = road k+1
- emg_req  input  4  level ambulance request; bit k = road k+1
- light_out  output  8  road k code at [2k+1:2k]: 00 OFF, 01 RED, 10 YELLOW, 11 GREEN
- grant_road  output  2  road currently owning / last owning the phase (0..3)
- phase  output  3  0 GREEN, 1 YELLOW, 2 ALL_RED, 3 EMG_GREEN
- emg_active  output  1  high in EMG_GREEN
- served  output  1  one-cycle pulse on each entry into GREEN or EMG_GREEN

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values: phase=GREEN, grant_road=0, timer=0, light_out=8'h57 (road1 G, others R), emg_active=0, served=0, emg target register=0.
- Timer: 32-bit, cleared on every state entry, +1 per cycle otherwise, saturates at all-ones. A state of duration T exits on the cycle where timer==T-1, so it occupies exactly T cycles.
- Outputs decode from registered state only. No combinational path from inputs to outputs.
- Light decode:
  - GREEN/EMG_GREEN: grant_road GREEN, others RED.
  - YELLOW: grant_road YELLOW, others RED.
  - ALL_RED: all RED.
  - OFF is never produced.
- Emergency target: lowest-index set bit of emg_req.
- Round-robin next road: first road with veh_req set, searching grant_road+1, +2, +3 (mod 4). The current road is not a candidate.
- GREEN transitions, in priority order:
  - emg_req≠0 and target==grant_road → EMG_GREEN (same road, no yellow).
  - emg_req≠0, other target → YELLOW immediately (min green waived).
  - timer≥T_MIN_GREEN-1 and another road requesting and (veh_req[grant_road]==0 or timer≥T_MAX_GREEN-1) → YELLOW.
  - Otherwise hold. With no other demand, green rests indefinitely.
- YELLOW: always served in full; never shortened. On exit, sample emg_req:
  - if nonzero, latch target;
  - else latch round-robin winner;
  - if neither, latch grant_road+1.
  - Then go to ALL_RED.
- ALL_RED: on exit, grant_road←latched road; go to EMG_GREEN if the latch came from an emergency, else GREEN.
- EMG_GREEN: hold while emg_req[grant_road]==1.
  - On release → YELLOW; the normal round-robin search then starts from that road.
  - A different road's emergency during EMG_GREEN waits until release.
- Simultaneous emergency and vehicle demand: emergency wins.
- emg_req that drops during YELLOW/ALL_RED after latching still receives one EMG_GREEN cycle, then releases.
- Reset mid-operation: all state returns to reset values asynchronously. No clearance is guaranteed across reset.

Optional Feature:
- Macro: ALL_RED_EN.
- Defined: ALL_RED state present as described.
- Undefined: YELLOW exit loads grant_road directly and enters GREEN/EMG_GREEN. Phase value 2 is never produced; T_ALL_RED is unused.

Test Plan:
All scenarios use T_MIN_GREEN=4, T_MAX_GREEN=8, T_YELLOW=2, T_ALL_RED=1, with ALL_RED_EN defined.
- Release reset, veh_req=0, emg_req=0 for 100 cycles → light_out stays 8'h57, phase=0, served pulses once at reset exit or never repeats.
- veh_req=4'b0100 from reset → road1 green 4 cycles, yellow 2 (light_out 8'h56), all-red 1 (8'h55), then grant_road=2, light_out 8'h75, served pulse.
- veh_req=4'b0011 held → road1 green exactly 8 cycles, then yellow, then road2 green.
- veh_req=4'b1111 held → grant order 0,1,2,3,0; each green is 8 cycles and each cycle is 11 cycles.
- emg_req=4'b1000 asserted on green cycle 1 of road1 → yellow 2, all-red 1, EMG_GREEN on road4 (light_out 8'hD5, emg_active=1) held 20 cycles; release → yellow 2, all-red 1, next round-robin road green.
- Assert reset during YELLOW → same cycle: phase=0, grant_road=0, light_out 8'h57; timer restarts at 0 after release.

Source files
------------

// File: rtl/traffic_phase_scheduler.sv
// Demand-driven phase scheduler for a four-road intersection.
// Round-robin arbitration over vehicle sensors with min/max green, yellow and
// optional all-red clearance; emergency requests preempt through a safe yellow.
// Optional feature macro: ALL_RED_EN (adds the ALL_RED clearance state).
module traffic_phase_scheduler #(
  parameter logic [31:0] T_MIN_GREEN = 32'd10000000,
  parameter logic [31:0] T_MAX_GREEN = 32'd40000000,
  parameter logic [31:0] T_YELLOW    = 32'd3000000,
  parameter logic [31:0] T_ALL_RED   = 32'd1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] veh_req,
  input  logic [3:0] emg_req,
  output logic [7:0] light_out,
  output logic [1:0] grant_road,
  output logic [2:0] phase,
  output logic       emg_active,
  output logic       served
);

  typedef enum logic [2:0] {
    StGreen    = 3'd0,
    StYellow   = 3'd1,
    StAllRed   = 3'd2,
    StEmgGreen = 3'd3
  } state_e;

  localparam logic [1:0] LightRed    = 2'b01;
  localparam logic [1:0] LightYellow = 2'b10;
  localparam logic [1:0] LightGreen  = 2'b11;

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [31:0] timer_q, timer_d;
  logic        served_q, served_d;

  logic        emg_any;
  logic [1:0]  emg_tgt;
  logic        rr_found;
  logic [1:0]  rr_road;
  logic [1:0]  rr_cand;
  logic [1:0]  yel_road;
  logic        yel_emg;
  logic        green_to_yellow;

`ifdef ALL_RED_EN
  logic [1:0]  latch_road_q, latch_road_d;
  logic        latch_emg_q, latch_emg_d;
`else
  // Clearance duration has no effect without the all-red state.
  logic        unused_t_all_red;
  assign unused_t_all_red = ^T_ALL_RED;
`endif

  // Emergency target: lowest-index asserted request.
  always_comb begin
    emg_any = |emg_req;
    emg_tgt = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (emg_req[i]) emg_tgt = 2'(i);
    end
  end

  // Round-robin winner: first requesting road after the current one.
  always_comb begin
    rr_found = 1'b0;
    rr_road  = grant_q;
    rr_cand  = 2'd0;
    for (int i = 3; i >= 1; i--) begin
      rr_cand = grant_q + 2'(i);
      if (veh_req[rr_cand]) begin
        rr_found = 1'b1;
        rr_road  = rr_cand;
      end
    end
  end

  // Road chosen at yellow exit: emergency first, then round-robin, then next road.
  always_comb begin
    yel_emg  = 1'b0;
    yel_road = grant_q + 2'd1;
    if (emg_any) begin
      yel_emg  = 1'b1;
      yel_road = emg_tgt;
    end else if (rr_found) begin
      yel_road = rr_road;
    end
  end

  // Normal green ends once min green is met and another road is waiting, and either
  // the current road went idle or max green expired.
  always_comb begin
    green_to_yellow = (timer_q >= T_MIN_GREEN - 32'd1) && rr_found &&
                      (!veh_req[grant_q] || (timer_q >= T_MAX_GREEN - 32'd1));
  end

  // Next-state logic: phase sequencing, grant hand-over, timer and served pulse.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
`ifdef ALL_RED_EN
    latch_road_d = latch_road_q;
    latch_emg_d  = latch_emg_q;
`endif
    case (state_q)
      StGreen: begin
        if (emg_any && (emg_tgt == grant_q)) begin
          state_d = StEmgGreen;
        end else if (emg_any || green_to_yellow) begin
          state_d = StYellow;
        end
      end
      StYellow: begin
        if (timer_q == T_YELLOW - 32'd1) begin
`ifdef ALL_RED_EN
          latch_road_d = yel_road;
          latch_emg_d  = yel_emg;
          state_d      = StAllRed;
`else
          grant_d = yel_road;
          state_d = yel_emg ? StEmgGreen : StGreen;
`endif
        end
      end
`ifdef ALL_RED_EN
      StAllRed: begin
        if (timer_q == T_ALL_RED - 32'd1) begin
          grant_d = latch_road_q;
          state_d = latch_emg_q ? StEmgGreen : StGreen;
        end
      end
`endif
      StEmgGreen: begin
        if (!emg_req[grant_q]) state_d = StYellow;
      end
      default: state_d = StGreen;
    endcase

    if (state_d != state_q) begin
      timer_d = 32'd0;
    end else if (timer_q == 32'hFFFF_FFFF) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + 32'd1;
    end

    served_d = (state_d != state_q) && ((state_d == StGreen) || (state_d == StEmgGreen));
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StGreen;
      grant_q  <= 2'd0;
      timer_q  <= 32'd0;
      served_q <= 1'b0;
`ifdef ALL_RED_EN
      latch_road_q <= 2'd0;
      latch_emg_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      timer_q  <= timer_d;
      served_q <= served_d;
`ifdef ALL_RED_EN
      latch_road_q <= latch_road_d;
      latch_emg_q  <= latch_emg_d;
`endif
    end
  end

  // Output decode from registered state only.
  always_comb begin
    light_out = {4{LightRed}};
    case (state_q)
      StGreen, StEmgGreen: light_out[{grant_q, 1'b0} +: 2] = LightGreen;
      StYellow:            light_out[{grant_q, 1'b0} +: 2] = LightYellow;
      default:             light_out = {4{LightRed}};
    endcase
    grant_road = grant_q;
    phase      = state_q;
    emg_active = (state_q == StEmgGreen);
    served     = served_q;
  end

endmodule
